rv32i_core: RTL and testbench



---
 rtl/rv32i_core.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_rv32i_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I integer core.
// Fetch, decode, execute, memory access and writeback all complete in one
// clock (CPI = 1). The core holds its own byte-addressed instruction memory,
// data memory, 32x32 register file, control decoder, ALU and branch
// comparator. Execution starts at address 0 after reset.
//
// Ports:
//   clk  in  1  core clock; all state updates on the rising edge
//   rst  in  1  asynchronous active-high reset (PC and x1..x31 cleared)
//
// Parameters:
//   IMEM_BYTES  instruction memory size in bytes (power of two)
//   DMEM_BYTES  data memory size in bytes (power of two)

// Instruction memory: byte array preloaded by the environment, combinational
// little-endian word read. Addresses wrap modulo IMEM_BYTES.
module rv32i_imem #(
    parameter int IMEM_BYTES = 4096,
    localparam int AW = $clog2(IMEM_BYTES)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);
    logic [7:0] mem [0:IMEM_BYTES-1];

    assign data = {mem[addr + AW'(3)], mem[addr + AW'(2)],
                   mem[addr + AW'(1)], mem[addr]};
endmodule

// Register file: two combinational reads, one write port on the rising edge.
// x0 always reads 0; a same-cycle read of the written register returns the
// old value.
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        reg_wr_en,
    input  logic [31:0] write_d,
    output logic [31:0] read_d1,
    output logic [31:0] read_d2
);
    logic [31:0] regs [0:31];
    logic        write_e;

    assign write_e = reg_wr_en && (rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (write_e) begin
            regs[rd] <= write_d;
        end
    end

    assign read_d1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign read_d2 = (rs2 == 5'd0) ? '0 : regs[rs2];
endmodule

// Data memory: byte array, combinational read, write on the rising edge.
// byt_en is an unshifted lane count (0001 byte, 0011 half, 1111 word);
// lanes map to consecutive byte addresses so misaligned access just works.
module rv32i_dmem #(
    parameter int DMEM_BYTES = 4096,
    localparam int AW = $clog2(DMEM_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    byt_en,
    input  logic          wr_en,
    input  logic          sign_ext,
    output logic [31:0]   rdata
);
    logic [7:0] mem [0:DMEM_BYTES-1];
    logic [7:0] b0, b1, b2, b3;

    assign b0 = mem[addr];
    assign b1 = mem[addr + AW'(1)];
    assign b2 = mem[addr + AW'(2)];
    assign b3 = mem[addr + AW'(3)];

    always_comb begin
        rdata = {b3, b2, b1, b0};
        case (byt_en)
            4'b0001: rdata = {{24{sign_ext & b0[7]}}, b0};
            4'b0011: rdata = {{16{sign_ext & b1[7]}}, b1, b0};
            default: rdata = {b3, b2, b1, b0};
        endcase
    end

    // Stores are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            if (byt_en[0]) mem[addr]          <= wdata[7:0];
            if (byt_en[1]) mem[addr + AW'(1)] <= wdata[15:8];
            if (byt_en[2]) mem[addr + AW'(2)] <= wdata[23:16];
            if (byt_en[3]) mem[addr + AW'(3)] <= wdata[31:24];
        end
    end
endmodule

// Control decoder: purely combinational from the instruction fields and the
// branch-compare result. Unknown opcodes, FENCE and SYSTEM fall to the
// defaults: no register write, no memory write, PC + 4.
module rv32i_ctrl (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       br_taken,
    output logic       sel_next_pc_alu_out,
    output logic       sel_wb,
    output logic       sel_alu_pc,
    output logic       sel_alu_imm,
    output logic [3:0] alu_op,
    output logic       sel_dmem_wb,
    output logic       mem_wr_en,
    output logic [3:0] mem_byt_en,
    output logic       sign_ext,
    output logic       reg_wr_en
);
    typedef enum logic [6:0] {
        OPC_LUI    = 7'h37,
        OPC_AUIPC  = 7'h17,
        OPC_JAL    = 7'h6f,
        OPC_JALR   = 7'h67,
        OPC_BRANCH = 7'h63,
        OPC_LOAD   = 7'h03,
        OPC_STORE  = 7'h23,
        OPC_OPIMM  = 7'h13,
        OPC_OP     = 7'h33
    } opcode_e;

    logic [3:0] lanes;

    always_comb begin
        case (funct3[1:0])
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_comb begin
        sel_next_pc_alu_out = 1'b0;
        sel_wb              = 1'b0;
        sel_alu_pc          = 1'b0;
        sel_alu_imm         = 1'b0;
        alu_op              = 4'b0000;
        sel_dmem_wb         = 1'b0;
        mem_wr_en           = 1'b0;
        mem_byt_en          = 4'b0000;
        sign_ext            = 1'b0;
        reg_wr_en           = 1'b0;
        case (opcode)
            OPC_OP: begin
                // funct7[5] selects SUB / SRA; alu_op low bits mirror funct3.
                alu_op    = {funct7_5 && (funct3 == 3'd0 || funct3 == 3'd5), funct3};
                reg_wr_en = 1'b1;
            end
            OPC_OPIMM: begin
                // Only SRAI uses funct7[5]; for ADDI it is an immediate bit.
                sel_alu_imm = 1'b1;
                alu_op      = {funct7_5 && (funct3 == 3'd5), funct3};
                reg_wr_en   = 1'b1;
            end
            OPC_LUI: begin
                sel_alu_imm = 1'b1;
                alu_op      = 4'b1111;
                reg_wr_en   = 1'b1;
            end
            OPC_AUIPC: begin
                sel_alu_pc  = 1'b1;
                sel_alu_imm = 1'b1;
                reg_wr_en   = 1'b1;
            end
            OPC_JAL: begin
                sel_alu_pc          = 1'b1;
                sel_alu_imm         = 1'b1;
                sel_next_pc_alu_out = 1'b1;
                sel_wb              = 1'b1;
                reg_wr_en           = 1'b1;
            end
            OPC_JALR: begin
                sel_alu_imm         = 1'b1;
                sel_next_pc_alu_out = 1'b1;
                sel_wb              = 1'b1;
                reg_wr_en           = 1'b1;
            end
            OPC_BRANCH: begin
                sel_alu_pc          = 1'b1;
                sel_alu_imm         = 1'b1;
                sel_next_pc_alu_out = br_taken;
            end
            OPC_LOAD: begin
                sel_alu_imm = 1'b1;
                sel_dmem_wb = 1'b1;
                mem_byt_en  = lanes;
                sign_ext    = !funct3[2] && (funct3[1:0] != 2'b10);
                reg_wr_en   = 1'b1;
            end
            OPC_STORE: begin
                sel_alu_imm = 1'b1;
                mem_wr_en   = 1'b1;
                mem_byt_en  = lanes;
            end
            default: ;
        endcase
    end
endmodule

module rv32i_core #(
    parameter int IMEM_BYTES = 4096,
    parameter int DMEM_BYTES = 4096
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = $clog2(IMEM_BYTES);
    localparam int DAW = $clog2(DMEM_BYTES);

    logic [31:0] pc_out, instruction, alu_out, reg_data1, reg_data2;
    logic [31:0] imm, alu_a, alu_b, pc_plus4, next_pc, load_data, wb_data;
    logic        br_taken, is_jalr;

    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        case (i[6:0])
            7'h23:        return {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63:        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17: return {i[31:12], 12'h000};
            7'h6f:        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:      return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, $signed(a) < $signed(b)};
            4'b0011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1000: return a - b;
            4'b1101: return $signed(a) >>> b[4:0];
            4'b1111: return b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic br_cmp(input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    logic       sel_next_pc_alu_out, sel_wb, sel_alu_pc, sel_alu_imm;
    logic       sel_dmem_wb, mem_wr_en, sign_ext, reg_wr_en;
    logic [3:0] alu_op, mem_byt_en;

    // PC: async reset to 0 aborts any pending next-state update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_out <= '0;
        else     pc_out <= next_pc;
    end

    rv32i_imem #(.IMEM_BYTES(IMEM_BYTES)) i_mem (
        .addr (pc_out[IAW-1:0]),
        .data (instruction)
    );

    rv32i_regfile rf (
        .clk       (clk),
        .rst       (rst),
        .rs1       (instruction[19:15]),
        .rs2       (instruction[24:20]),
        .rd        (instruction[11:7]),
        .reg_wr_en (reg_wr_en),
        .write_d   (wb_data),
        .read_d1   (reg_data1),
        .read_d2   (reg_data2)
    );

    assign br_taken = br_cmp(instruction[14:12], reg_data1, reg_data2);

    rv32i_ctrl ctrl (
        .opcode              (instruction[6:0]),
        .funct3              (instruction[14:12]),
        .funct7_5            (instruction[30]),
        .br_taken            (br_taken),
        .sel_next_pc_alu_out (sel_next_pc_alu_out),
        .sel_wb              (sel_wb),
        .sel_alu_pc          (sel_alu_pc),
        .sel_alu_imm         (sel_alu_imm),
        .alu_op              (alu_op),
        .sel_dmem_wb         (sel_dmem_wb),
        .mem_wr_en           (mem_wr_en),
        .mem_byt_en          (mem_byt_en),
        .sign_ext            (sign_ext),
        .reg_wr_en           (reg_wr_en)
    );

    assign imm     = imm_gen(instruction);
    assign alu_a   = sel_alu_pc  ? pc_out : reg_data1;
    assign alu_b   = sel_alu_imm ? imm    : reg_data2;
    assign alu_out = alu(alu_op, alu_a, alu_b);

    rv32i_dmem #(.DMEM_BYTES(DMEM_BYTES)) d_mem (
        .clk      (clk),
        .rst      (rst),
        .addr     (alu_out[DAW-1:0]),
        .wdata    (reg_data2),
        .byt_en   (mem_byt_en),
        .wr_en    (mem_wr_en),
        .sign_ext (sign_ext),
        .rdata    (load_data)
    );

    assign pc_plus4 = pc_out + 32'd4;
    assign is_jalr  = (instruction[6:0] == 7'h67);
    assign next_pc  = !sel_next_pc_alu_out ? pc_plus4 :
                      is_jalr ? {alu_out[31:1], 1'b0} : alu_out;
    assign wb_data  = sel_wb ? pc_plus4 : (sel_dmem_wb ? load_data : alu_out);
endmodule

// File: tb/tb_rv32i_core.sv
// Testbench for rv32i_core: directed programs from the test plan plus a
// randomly generated program, all checked cycle by cycle against an
// instruction-level reference model of RV32I kept in this file.
module tb_rv32i_core;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_core #(.IMEM_BYTES(N), .DMEM_BYTES(N)) dut (.clk(clk), .rst(rst));

    int ncmp = 0;
    int nfail = 0;

    logic [7:0]  m_im [N];
    logic [7:0]  m_dm [N];
    logic [31:0] m_x  [32];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            m_im[a+k] = w[8*k +: 8];
            dut.i_mem.mem[a+k] = w[8*k +: 8];
        end
    endtask

    task automatic fill_nop();
        for (int a = 0; a < N; a += 4) put_word(a, 32'h0000_0013);
    endtask

    // Reference model: execute one instruction at m_pc.
    function automatic void m_step();
        logic [31:0] ins, r1, r2, val, npc, a, b, ii, is, ib, iu, ij;
        logic [11:0] p;
        logic        wr, take;
        p   = m_pc[11:0];
        ins = {m_im[p+12'd3], m_im[p+12'd2], m_im[p+12'd1], m_im[p]};
        r1  = m_x[ins[19:15]];
        r2  = m_x[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu  = {ins[31:12], 12'h0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        npc = m_pc + 4;
        wr  = 1'b0;
        val = '0;
        case (ins[6:0])
            7'h37: begin wr = 1; val = iu; end
            7'h17: begin wr = 1; val = m_pc + iu; end
            7'h6f: begin wr = 1; val = m_pc + 4; npc = m_pc + ij; end
            7'h67: begin wr = 1; val = m_pc + 4; npc = (r1 + ii) & ~32'd1; end
            7'h63: begin
                case (ins[14:12])
                    3'd0: take = (r1 == r2);
                    3'd1: take = (r1 != r2);
                    3'd4: take = ($signed(r1) <  $signed(r2));
                    3'd5: take = ($signed(r1) >= $signed(r2));
                    3'd6: take = (r1 <  r2);
                    3'd7: take = (r1 >= r2);
                    default: take = 0;
                endcase
                if (take) npc = m_pc + ib;
            end
            7'h03: begin
                a = r1 + ii;
                wr = 1;
                case (ins[14:12])
                    3'd0: val = {{24{m_dm[a[11:0]][7]}}, m_dm[a[11:0]]};
                    3'd1: val = {{16{m_dm[a[11:0]+12'd1][7]}}, m_dm[a[11:0]+12'd1], m_dm[a[11:0]]};
                    3'd4: val = {24'h0, m_dm[a[11:0]]};
                    3'd5: val = {16'h0, m_dm[a[11:0]+12'd1], m_dm[a[11:0]]};
                    default: val = {m_dm[a[11:0]+12'd3], m_dm[a[11:0]+12'd2],
                                    m_dm[a[11:0]+12'd1], m_dm[a[11:0]]};
                endcase
            end
            7'h23: begin
                a = r1 + is;
                for (int k = 0; k < (ins[14:12] == 3'd0 ? 1 : ins[14:12] == 3'd1 ? 2 : 4); k++)
                    m_dm[a[11:0] + 12'(k)] = r2[8*k +: 8];
            end
            7'h13, 7'h33: begin
                b  = (ins[6:0] == 7'h13) ? ii : r2;
                wr = 1;
                case (ins[14:12])
                    3'd0: val = (ins[6:0] == 7'h33 && ins[30]) ? r1 - b : r1 + b;
                    3'd1: val = r1 << b[4:0];
                    3'd2: val = ($signed(r1) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: val = (r1 < b) ? 32'd1 : 32'd0;
                    3'd4: val = r1 ^ b;
                    3'd5: val = ins[30] ? 32'($signed(r1) >>> b[4:0]) : r1 >> b[4:0];
                    3'd6: val = r1 | b;
                    default: val = r1 & b;
                endcase
            end
            default: ;
        endcase
        if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = val;
        m_pc = npc;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        logic [2:0] f3;
        w   = $urandom;
        sel = $urandom_range(0, 99);
        f3  = w[14:12];
        if (sel < 30) begin
            w[6:0] = 7'h13;
            if (f3 == 3'd1) w[31:25] = 7'h00;
            if (f3 == 3'd5) w[31:25] = w[30] ? 7'h20 : 7'h00;
        end else if (sel < 50) begin
            w[6:0] = 7'h33;
            w[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && w[30]) ? 7'h20 : 7'h00;
        end else if (sel < 55) w[6:0] = 7'h37;
        else if (sel < 60) w[6:0] = 7'h17;
        else if (sel < 70) begin
            w[6:0] = 7'h03;
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) w[14:12] = 3'd2;
        end else if (sel < 80) begin
            w[6:0] = 7'h23;
            w[14:12] = 3'($urandom_range(0, 2));
        end else if (sel < 90) begin
            w[6:0] = 7'h63;
            if (f3 == 3'd2 || f3 == 3'd3) w[14:12] = 3'd0;
        end else if (sel < 93) w[6:0] = 7'h6f;
        else if (sel < 96) begin
            w[6:0] = 7'h67;
            w[14:12] = 3'd0;
        end else begin
            case ($urandom_range(0, 3))
                0: w = 32'h0000_000f;
                1: w = 32'h0000_0073;
                2: w = 32'h0010_0073;
                default: w[6:0] = 7'h0b;
            endcase
        end
        return w;
    endfunction

    task automatic enter_reset();
        rst = 1'b1;
        #1;
        m_pc = '0;
        for (int r = 0; r < 32; r++) m_x[r] = '0;
        chk("rst_pc", dut.pc_out, 32'h0);
        for (int r = 1; r < 32; r++) chk($sformatf("rst_x%0d", r), dut.rf.regs[r], 32'h0);
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_pc", dut.pc_out, 32'h0);
    endtask

    task automatic run(input int n);
        for (int s = 0; s < n; s++) begin
            m_step();
            @(posedge clk);
            #1;
            chk("pc", dut.pc_out, m_pc);
            for (int r = 0; r < 32; r++) chk($sformatf("x%0d", r), dut.rf.regs[r], m_x[r]);
        end
    endtask

    logic [31:0] prog1 [$];
    logic [31:0] prog2 [$];
    logic [7:0]  saved101;

    initial begin
        prog1 = '{32'h00500093, 32'hffd00113, 32'h002081b3, 32'h40208233,
                  32'h00001317, 32'h123452b7, 32'h10000393, 32'h08000093,
                  32'h00138023, 32'h00038403, 32'h0003c483, 32'hdeadc537,
                  32'heef50513, 32'h00a3a023, 32'h00239583, 32'h80000637,
                  32'h40465693, 32'h00108463, 32'h00100713, 32'h00109463,
                  32'h00200793, 32'h00100073};
        prog2 = '{32'h00000013, 32'h00700013, 32'h00100073, 32'h00000013,
                  32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013,
                  32'h00c000ef, 32'h01008093, 32'h00000013, 32'h00108067};
        rst = 1'b0;
        for (int a = 0; a < N; a++) begin
            m_dm[a] = 8'($urandom);
            dut.d_mem.mem[a] = m_dm[a];
        end
        saved101 = m_dm[12'h101];
        fill_nop();
        #1;
        enter_reset();
        #10;
        chk("rst_hold_pc", dut.pc_out, 32'h0);

        // Program 1: ALU, upper immediates, loads/stores, branches.
        for (int i = 0; i < prog1.size(); i++) put_word(4*i, prog1[i]);
        leave_reset();
        run(9);
        chk("sb_byte100", 32'(dut.d_mem.mem[12'h100]), 32'h80);
        chk("sb_byte101", 32'(dut.d_mem.mem[12'h101]), 32'(saved101));
        run(15);
        chk("add_x3",  dut.rf.regs[3],  32'h0000_0002);
        chk("sub_x4",  dut.rf.regs[4],  32'h0000_0008);
        chk("lui_x5",  dut.rf.regs[5],  32'h1234_5000);
        chk("auipc_x6", dut.rf.regs[6], 32'h0000_1010);
        chk("lb_x8",   dut.rf.regs[8],  32'hffff_ff80);
        chk("lbu_x9",  dut.rf.regs[9],  32'h0000_0080);
        chk("lh_x11",  dut.rf.regs[11], 32'hffff_dead);
        chk("sra_x13", dut.rf.regs[13], 32'hf800_0000);
        chk("beq_skip_x14", dut.rf.regs[14], 32'h0);
        chk("bne_fall_x15", dut.rf.regs[15], 32'h2);
        chk("sw_word", {dut.d_mem.mem[12'h103], dut.d_mem.mem[12'h102],
                        dut.d_mem.mem[12'h101], dut.d_mem.mem[12'h100]}, 32'hdead_beef);
        chk("p1_end_pc", dut.pc_out, 32'h64);

        // Reset in the middle of a cycle, then program 2: NOPs, x0 write,
        // EBREAK, JAL / JALR.
        #2;
        enter_reset();
        fill_nop();
        for (int i = 0; i < prog2.size(); i++) put_word(4*i, prog2[i]);
        leave_reset();
        run(1);
        chk("x0_instr", dut.instruction, 32'h0070_0013);
        chk("x0_write_e", 32'(dut.rf.write_e), 32'h0);
        run(1);
        chk("ebreak_instr", dut.instruction, 32'h0010_0073);
        chk("ebreak_write_e", 32'(dut.rf.write_e), 32'h0);
        chk("ebreak_mem_wr", 32'(dut.ctrl.mem_wr_en), 32'h0);
        run(1);
        chk("ebreak_pc", dut.pc_out, 32'h0c);
        chk("x0_zero", dut.rf.read_d1 | 32'(dut.rf.regs[0]), 32'h0);
        run(6);
        chk("jal_pc", dut.pc_out, 32'h2c);
        chk("jal_x1", dut.rf.regs[1], 32'h24);
        run(1);
        chk("jalr_pc", dut.pc_out, 32'h24);
        run(4);

        // Random program over the whole instruction memory.
        #2;
        enter_reset();
        for (int a = 0; a < N; a += 4) put_word(a, rand_instr());
        leave_reset();
        run(400);
        for (int a = 0; a < N; a += 4)
            chk($sformatf("dmem_%0h", a),
                {dut.d_mem.mem[a+3], dut.d_mem.mem[a+2], dut.d_mem.mem[a+1], dut.d_mem.mem[a]},
                {m_dm[a+3], m_dm[a+2], m_dm[a+1], m_dm[a]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
